// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-rate divider, h/v counters, registered sync/de outputs
// and a pixel-tick delay line for the sync/de copies.
module vga_timing_gen #(
  parameter int DIV      = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int LAT      = 1,
  parameter int CW       = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic          pix_ce,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          de,
  output logic          hs,
  output logic          vs,
  output logic          line_start,
  output logic          frame_start,
  output logic          hs_d,
  output logic          vs_d,
  output logic          de_d
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  localparam logic [CW-1:0] H_LAST   = CW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic HS_ON = (HS_POL != 0);
  localparam logic VS_ON = (VS_POL != 0);

  logic [DW-1:0] divCnt;
  logic [CW-1:0] hCnt, vCnt, hNext, vNext;
  logic          deNext, hsNext, vsNext;

  assign pix_ce = en && (divCnt == DIV_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      divCnt <= '0;
    end else if (en) begin
      divCnt <= (divCnt == DIV_LAST) ? '0 : divCnt + DW'(1);
    end
  end

  always_comb begin
    hNext = hCnt + CW'(1);
    vNext = vCnt;
    if (hCnt == H_LAST) begin
      hNext = '0;
      vNext = (vCnt == V_LAST) ? '0 : vCnt + CW'(1);
    end
    deNext = (hNext < H_ACT) && (vNext < V_ACT);
    hsNext = (hNext >= HS_START && hNext < HS_END) ? HS_ON : !HS_ON;
    vsNext = (vNext >= VS_START && vNext < VS_END) ? VS_ON : !VS_ON;
  end

  // Counters start at the last position so the first tick lands on (0,0).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hCnt        <= H_LAST;
      vCnt        <= V_LAST;
      x           <= '0;
      y           <= '0;
      de          <= 1'b0;
      hs          <= !HS_ON;
      vs          <= !VS_ON;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (pix_ce) begin
        hCnt        <= hNext;
        vCnt        <= vNext;
        x           <= hNext;
        y           <= vNext;
        de          <= deNext;
        hs          <= hsNext;
        vs          <= vsNext;
        line_start  <= (hNext == '0);
        frame_start <= (hNext == '0) && (vNext == '0);
      end
    end
  end

  generate
    if (LAT == 0) begin : g_nodly
      assign {hs_d, vs_d, de_d} = {hs, vs, de};
    end else begin : g_dly
      logic [2:0] dly [LAT];

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int i = 0; i < LAT; i++) dly[i] <= {!HS_ON, !VS_ON, 1'b0};
        end else if (pix_ce) begin
          dly[0] <= {hs, vs, de};
          for (int i = 1; i < LAT; i++) dly[i] <= dly[i-1];
        end
      end

      assign {hs_d, vs_d, de_d} = dly[LAT-1];
    end
  endgenerate

endmodule
